// File: rtl/fp_add_rr_sched.sv
// fp_add_rr_sched: round-robin scheduler that time-shares a single FP32 adder
// among NREQ requesters. It never looks inside the FP fields; it only moves
// operands to the adder and carries the result back with the requester ID.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req_valid/req_ready per-requester request handshake (req_ready one-hot)
//   req_a, req_b        packed operands, requester i at [32*i+31:32*i]
//   add_a, add_b        operands held on the shared adder
//   add_res             combinational adder result
//   rsp_valid/rsp_ready response handshake
//   rsp_res, rsp_id     captured sum and owning requester index
//   busy                high whenever the scheduler is not idle
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold operands stable while valid and not ready;
// rsp_res/rsp_id stay stable while rsp_valid is high and rsp_ready is low.
module fp_add_rr_sched #(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 1,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    input  logic [31:0]          add_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_res,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    localparam int CW = $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] grant_id_q;
    logic [CW-1:0]  cnt_q;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] scan_idx;
    logic [31:0]    win_a, win_b;

    // Rotating priority search starting at ptr. The wrap is an explicit
    // compare so non power-of-two NREQ works.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
            scan_idx = (scan_idx == IDW'(NREQ - 1)) ? '0 : scan_idx + IDW'(1);
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                win_a = req_a[32*k +: 32];
                win_b = req_b[32*k +: 32];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_found)           state_d = S_EXEC;
            S_EXEC:  if (cnt_q == CW'(1))       state_d = S_RESP;
            S_RESP:  if (rsp_ready)             state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. req_ready is suppressed during reset so nothing can
    // appear to transfer on a reset edge.
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == S_IDLE && grant_found)
            req_ready[grant_idx] = 1'b1;
        busy = (state_q != S_IDLE);
    end

    // Datapath registers. add_a/add_b change only on a grant, so the adder
    // inputs are quiet while idle or waiting on the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            grant_id_q <= '0;
            cnt_q      <= '0;
            add_a      <= '0;
            add_b      <= '0;
            rsp_res    <= '0;
            rsp_id     <= '0;
            rsp_valid  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        add_a      <= win_a;
                        add_b      <= win_b;
                        grant_id_q <= grant_idx;
                        cnt_q      <= CW'(ADD_LAT);
                    end
                end
                S_EXEC: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rsp_res   <= add_res;
                        rsp_id    <= grant_id_q;
                        rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    // Priority moves past the requester just served, and only here.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr_q     <= (grant_id_q == IDW'(NREQ - 1)) ? '0
                                                                   : grant_id_q + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
